// File: rtl/bus_arbiter.sv
// N-requester system-bus arbiter: registered one-hot grant, hold-while-busy, one-cycle turnaround.
// Optional grant watchdog built only when BUS_ARB_TIMEOUT_EN is defined.

module bus_arb_slot #(
   parameter int ID_W = 2,
   parameter int IDX  = 0,
   parameter int EN   = 1
) (
   input  logic            req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic            req_hi
);

   // Request at or above the round-robin pointer; these take precedence over wrapped ones.
   assign req_hi = (EN != 0) && req && (ID_W'(IDX) >= rr_ptr);

endmodule

module bus_arbiter #(
   parameter int NUM_REQ        = 3,
   parameter int ROUND_ROBIN    = 1,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int ID_W           = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] in_reqcyc,
   input  logic [NUM_REQ-1:0] in_busy,
   output logic [NUM_REQ-1:0] out_grant,
   output logic               out_grant_valid,
   output logic [ID_W-1:0]    out_grant_id,
   output logic               out_bus_busy,
   output logic               out_timeout
);

   typedef enum logic [1:0] {IDLE, GRANT, HOLD, RELEASE} state_t;

   if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
      $error("bus_arbiter: NUM_REQ must be 2..16");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("bus_arbiter: TIMEOUT_CYCLES must be >= 1");
   end

   state_t               state_q, state_n;
   logic [NUM_REQ-1:0]   grant_q, grant_n;
   logic [ID_W-1:0]      gid_q, gid_n;
   logic [ID_W-1:0]      rr_ptr, ptr_n, ptr_rel;
   logic                 valid_q;
   logic                 to_q, to_n;
   logic                 armed_q;
   logic                 rel;
   logic                 own_busy, own_req;
   logic                 wd_expired;
   logic [NUM_REQ-1:0]   req_hi, req_sel, win_oh;
   logic [ID_W-1:0]      win_id;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slot
      bus_arb_slot #(.ID_W(ID_W), .IDX(i), .EN(ROUND_ROBIN)) u_slot (
         .req    (in_reqcyc[i]),
         .rr_ptr (rr_ptr),
         .req_hi (req_hi[i])
      );
   end

   // Lowest set bit of the pointer-masked set, falling back to the wrapped set.
   assign req_sel = (|req_hi) ? req_hi : in_reqcyc;
   assign win_oh  = req_sel & (~req_sel + NUM_REQ'(1));

   always_comb begin
      win_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) win_id = ID_W'(i);
      end
   end

   // grant_q is zero outside GRANT/HOLD, so masking with it selects only the owner.
   assign own_busy = |(in_busy & grant_q);
   assign own_req  = |(in_reqcyc & grant_q);
   assign ptr_rel  = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + ID_W'(1);

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                wd_cnt <= '0;
      else if (state_q != GRANT) wd_cnt <= '0;
      else                       wd_cnt <= wd_cnt + CW'(1);
   end

   assign wd_expired = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign wd_expired = 1'b0;
`endif

   always_comb begin
      state_n = state_q;
      grant_n = grant_q;
      gid_n   = gid_q;
      ptr_n   = rr_ptr;
      to_n    = 1'b0;
      rel     = 1'b0;
      case (state_q)
         IDLE: begin
            // armed_q holds off arbitration on the first edge after reset release.
            if (armed_q && |in_reqcyc) begin
               state_n = GRANT;
               grant_n = win_oh;
               gid_n   = win_id;
            end
         end
         GRANT: begin
            if (own_busy)        state_n = HOLD;
            else if (!own_req)   rel = 1'b1;
            else if (wd_expired) begin
               rel  = 1'b1;
               to_n = 1'b1;
            end
         end
         HOLD: begin
            if (!own_busy) rel = 1'b1;
         end
         RELEASE: begin
            if (|in_reqcyc) begin
               state_n = GRANT;
               grant_n = win_oh;
               gid_n   = win_id;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // Pointer moves on entry to RELEASE so that cycle's arbitration already sees it.
      if (rel) begin
         state_n = RELEASE;
         grant_n = '0;
         gid_n   = '0;
         if (ROUND_ROBIN != 0) ptr_n = ptr_rel;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         rr_ptr  <= '0;
         valid_q <= 1'b0;
         to_q    <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         state_q <= state_n;
         grant_q <= grant_n;
         gid_q   <= gid_n;
         rr_ptr  <= ptr_n;
         valid_q <= |grant_n;
         to_q    <= to_n;
         armed_q <= 1'b1;
      end
   end

   assign out_grant       = grant_q;
   assign out_grant_valid = valid_q;
   assign out_grant_id    = gid_q;
   assign out_bus_busy    = own_busy;
   assign out_timeout     = to_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: round-robin and fixed-priority instances, NUM_REQ=3, TIMEOUT_CYCLES=4.
// Vector table plus hand sequences for mid-transaction reset and the watchdog / no-watchdog hold.

module tb_bus_arbiter;

   typedef struct {
      bit         fp;
      logic [2:0] req;
      logic [2:0] busy;
      logic [2:0] g;
      logic [1:0] id;
      logic       bb;
      logic       to;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] rr_req = '0, rr_busy = '0, fp_req = '0, fp_busy = '0;
   logic [2:0] rr_g, fp_g;
   logic       rr_v, fp_v, rr_bb, fp_bb, rr_to, fp_to;
   logic [1:0] rr_id, fp_id;

   int checks = 0;
   int errors = 0;
   int row_no = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   always #5 clk = ~clk;

   bus_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(4)) u_rr (
      .clk(clk), .reset(reset), .in_reqcyc(rr_req), .in_busy(rr_busy),
      .out_grant(rr_g), .out_grant_valid(rr_v), .out_grant_id(rr_id),
      .out_bus_busy(rr_bb), .out_timeout(rr_to)
   );

   bus_arbiter #(.NUM_REQ(3), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(4)) u_fp (
      .clk(clk), .reset(reset), .in_reqcyc(fp_req), .in_busy(fp_busy),
      .out_grant(fp_g), .out_grant_valid(fp_v), .out_grant_id(fp_id),
      .out_bus_busy(fp_bb), .out_timeout(fp_to)
   );

   function automatic vec_t mk(bit fp, logic [2:0] req, logic [2:0] busy,
                               logic [2:0] g, logic [1:0] id, logic bb, logic to);
      vec_t v;
      v.fp = fp; v.req = req; v.busy = busy; v.g = g; v.id = id; v.bb = bb; v.to = to;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {grant,valid,id,busy,timeout}=%b expected %b", nm, act, exp);
      end
   endtask

   // Drive a row on the falling edge, queue its expectation, compare after the next rising edge.
   task automatic apply(input vec_t v);
      vec_t e;
      @(negedge clk);
      if (v.fp) begin
         fp_req = v.req; fp_busy = v.busy; rr_req = '0; rr_busy = '0;
      end else begin
         rr_req = v.req; rr_busy = v.busy; fp_req = '0; fp_busy = '0;
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      if (e.fp) chk($sformatf("fp_row%0d", row_no), {fp_g, fp_v, fp_id, fp_bb, fp_to},
                    {e.g, |e.g, e.id, e.bb, e.to});
      else      chk($sformatf("rr_row%0d", row_no), {rr_g, rr_v, rr_id, rr_bb, rr_to},
                    {e.g, |e.g, e.id, e.bb, e.to});
      row_no++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "time limit");
   end

   initial begin
      // first grant only on the second edge after reset release
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b100, 3'b100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 3'b000, 3'b100, 3'b100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      // round-robin wrap 0,1,2,0
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b001, 3'b001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b001, 3'b001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b010, 2'd1, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b100, 2'd2, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b100, 3'b100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b100, 3'b100, 2'd2, 1, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b111, 3'b000, 3'b001, 2'd0, 0, 0));
      // abandoned request, then pending requester 1
      tbl.push_back(mk(0, 3'b110, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b110, 3'b000, 3'b010, 2'd1, 0, 0));
      // busy rise and reqcyc fall together: busy wins
      tbl.push_back(mk(0, 3'b100, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 3'b100, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
      // non-owner busy ignored; GRANT cycles 2..4 without owner busy
      tbl.push_back(mk(0, 3'b100, 3'b011, 3'b100, 2'd2, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
`ifdef BUS_ARB_TIMEOUT_EN
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b000, 2'd0, 0, 1));
`else
      tbl.push_back(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
`endif
      tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b011, 3'b000, 3'b001, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b011, 3'b001, 3'b001, 2'd0, 1, 0));
      tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      // fixed priority: requester 1 keeps winning over 2
      tbl.push_back(mk(1, 3'b110, 3'b000, 3'b010, 2'd1, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(1, 3'b110, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 3'b010, 2'd1, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(1, 3'b110, 3'b000, 3'b010, 2'd1, 0, 0));
      tbl.push_back(mk(1, 3'b100, 3'b010, 3'b010, 2'd1, 1, 0));
      tbl.push_back(mk(1, 3'b100, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(1, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
      tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      tbl.push_back(mk(1, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));

      repeat (2) @(posedge clk);
      #1;
      chk("reset_rr", {rr_g, rr_v, rr_id, rr_bb, rr_to}, 8'h00);
      chk("reset_fp", {fp_g, fp_v, fp_id, fp_bb, fp_to}, 8'h00);
      #1 reset = 1'b1;

      foreach (tbl[i]) apply(tbl[i]);

      // asynchronous reset in the middle of HOLD
      apply(mk(0, 3'b010, 3'b000, 3'b010, 2'd1, 0, 0));
      apply(mk(0, 3'b010, 3'b010, 3'b010, 2'd1, 1, 0));
      #3 reset = 1'b0;
      #1;
      chk("reset_mid_hold", {rr_g, rr_v, rr_id, rr_bb, rr_to}, 8'h00);
      @(negedge clk);
      rr_req = '0; rr_busy = '0;
      @(posedge clk);
      #1;
      chk("reset_held", {rr_g, rr_v, rr_id, rr_bb, rr_to}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      apply(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));

      // owner 2 granted, never busy: watchdog revokes after 4 GRANT cycles, else held
`ifdef BUS_ARB_TIMEOUT_EN
      for (int k = 1; k <= 4; k++)
         if (k == 4) apply(mk(0, 3'b100, 3'b000, 3'b000, 2'd0, 0, 1));
         else        apply(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
`else
      for (int k = 1; k <= 110; k++)
         apply(mk(0, 3'b100, 3'b000, 3'b100, 2'd2, 0, 0));
`endif
      apply(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));
      apply(mk(0, 3'b000, 3'b000, 3'b000, 2'd0, 0, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
